// File: rtl/trees_acc_pkg.sv
// Shared constants and FSM state type for the tree accelerator, its feature
// loader and their benches.
package trees_acc_pkg;

  localparam int N_FEATURE      = 32;
  localparam int HALF_FEATURE   = N_FEATURE / 2;
  localparam int MAX_BURST      = 54;
  localparam int MAX_BURST_BITS = $clog2(MAX_BURST);
  // Wide enough for MAX_BURST * HALF_FEATURE = 864 beats.
  localparam int BEAT_CNT_BITS  = 10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    START,
    WAIT
  } load_state_t;

endpackage

// File: rtl/feature_burst_loader.sv
// Streams a burst of feature samples into the tree accelerator's feature
// buffer, then starts the accelerator and waits for its done edge.
module feature_burst_loader
  import trees_acc_pkg::*;
#(
  parameter  int N_FEATURE      = trees_acc_pkg::N_FEATURE,
  parameter  int MAX_BURST      = trees_acc_pkg::MAX_BURST,
  localparam int HALF_FEATURE   = N_FEATURE / 2,
  localparam int MAX_BURST_BITS = $clog2(MAX_BURST)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [MAX_BURST_BITS-1:0] cmd_n_samples,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [63:0]               s_data,
  output logic                      load_features,
  output logic [31:0]               feature_addr,
  output logic [63:0]               features2,
  output logic                      start,
  output logic [MAX_BURST_BITS-1:0] burst_len,
  input  logic                      done,
  output logic                      busy,
  output logic                      err_len
);

  load_state_t              state;
  logic [BEAT_CNT_BITS-1:0] beat_cnt;
  logic [BEAT_CNT_BITS-1:0] last_beat;
  logic                     done_q;

  // Handshakes are gated by rst so nothing is accepted in the reset cycle,
  // and cmd_ready rises in the very first cycle after reset is released.
  assign cmd_ready = (state == IDLE) && !rst;
  assign s_ready   = (state == LOAD) && !rst;
  assign busy      = (state != IDLE);

  assign last_beat = BEAT_CNT_BITS'(int'(burst_len) * HALF_FEATURE - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      load_features <= 1'b0;
      feature_addr  <= '0;
      features2     <= '0;
      start         <= 1'b0;
      burst_len     <= '0;
      err_len       <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      err_len       <= 1'b0;
      start         <= 1'b0;
      load_features <= 1'b0;
      done_q        <= done;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_n_samples == '0 || int'(cmd_n_samples) > MAX_BURST) begin
              err_len <= 1'b1;
            end else begin
              burst_len <= cmd_n_samples;
              beat_cnt  <= '0;
              state     <= LOAD;
            end
          end
        end
        LOAD: begin
          if (s_valid) begin
            load_features <= 1'b1;
            features2     <= s_data;
            feature_addr  <= 32'(beat_cnt);
            beat_cnt      <= beat_cnt + 1'b1;
            if (beat_cnt == last_beat) state <= FLUSH;
          end
        end
        // The last write is on the bus during FLUSH; start follows it.
        FLUSH: begin
          start <= 1'b1;
          state <= START;
        end
        START: state <= WAIT;
        // Only a fresh rising edge of done ends the run.
        WAIT: if (done && !done_q) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_feature_burst_loader.sv
// Scoreboard bench for feature_burst_loader: drivers queue expected writes,
// a negedge monitor pops and compares them and tracks start/err pulses.
module tb_feature_burst_loader;
  import trees_acc_pkg::*;

  localparam int NB = MAX_BURST_BITS;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [NB-1:0] cmd_n_samples;
  logic          s_valid;
  logic          s_ready;
  logic [63:0]   s_data;
  logic          load_features;
  logic [31:0]   feature_addr;
  logic [63:0]   features2;
  logic          start;
  logic [NB-1:0] burst_len;
  logic          done;
  logic          busy;
  logic          err_len;

  always #5 clk = ~clk;

  feature_burst_loader dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_n_samples (cmd_n_samples),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .load_features (load_features),
    .feature_addr  (feature_addr),
    .features2     (features2),
    .start         (start),
    .burst_len     (burst_len),
    .done          (done),
    .busy          (busy),
    .err_len       (err_len)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           mon_e;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            last_wr_cyc = -10;
  int            start_cnt = 0;
  int            err_cnt = 0;
  int            wr_cnt = 0;
  logic [NB-1:0] exp_len = '0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    return {32'hA500_0000 + 32'(i), 32'h3C00_0000 ^ 32'(i * 7)};
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (load_features) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 96'(feature_addr), 96'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", 96'(feature_addr), 96'(mon_e.addr));
        chk("write_data", 96'(features2), 96'(mon_e.data));
      end
    end
    if (start) begin
      start_cnt++;
      chk("start_after_flush", 96'(cyc), 96'(last_wr_cyc + 1));
      chk("start_no_load", 96'(load_features), 96'(0));
      chk("start_burst_len", 96'(burst_len), 96'(exp_len));
    end
    if (err_len) err_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int n);
    bit ok;
    ok = 1'b0;
    cmd_valid     = 1'b1;
    cmd_n_samples = NB'(n);
    for (int g = 0; g < 20 && !ok; g++) begin
      ok = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    chk("cmd_accepted", 96'(ok), 96'(1));
  endtask

  task automatic send_beats(input int total, input bit gaps);
    int i;
    i = 0;
    for (int g = 0; g < 20000 && i < total; g++) begin
      s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data  = pat(i);
      if (s_valid && s_ready) begin
        exp_q.push_back({32'(i), pat(i)});
        i++;
      end
      tick();
    end
    s_valid = 1'b0;
    chk("beats_accepted", 96'(i), 96'(total));
  endtask

  task automatic finish_burst(input int starts_before);
    for (int g = 0; g < 40 && start_cnt == starts_before; g++) tick();
    chk("one_start", 96'(start_cnt), 96'(starts_before + 1));
    repeat (3) tick();
    chk("busy_in_wait", 96'(busy), 96'(1));
    done = 1'b1;
    tick();
    done = 1'b0;
    for (int g = 0; g < 10 && !cmd_ready; g++) tick();
    chk("idle_cmd_ready", 96'(cmd_ready), 96'(1));
    chk("idle_busy", 96'(busy), 96'(0));
  endtask

  initial begin
    int s0, w0, e0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_n_samples = '0;
    s_valid = 1'b0; s_data = '0; done = 1'b0;
    repeat (3) tick();
    chk("rst_cmd_ready", 96'(cmd_ready), 96'(0));
    chk("rst_outputs", {s_ready, load_features, start, busy, err_len, burst_len},
        96'(0));
    chk("rst_addr_data", {feature_addr, features2}, 96'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_ready", 96'(cmd_ready), 96'(1));

    // n=1, back-to-back beats
    exp_len = 1; s0 = start_cnt; w0 = wr_cnt;
    send_cmd(1);
    send_beats(16, 1'b0);
    finish_burst(s0);
    chk("n1_writes", 96'(wr_cnt - w0), 96'(16));

    // n=54 with random s_valid gaps
    exp_len = 54; s0 = start_cnt; w0 = wr_cnt;
    send_cmd(54);
    send_beats(864, 1'b1);
    finish_burst(s0);
    chk("n54_writes", 96'(wr_cnt - w0), 96'(864));
    chk("n54_queue_empty", 96'(exp_q.size()), 96'(0));

    // illegal lengths
    s0 = start_cnt; w0 = wr_cnt; e0 = err_cnt;
    send_cmd(0);
    chk("err0_busy", 96'(busy), 96'(0));
    send_cmd(60);
    chk("err60_busy", 96'(busy), 96'(0));
    repeat (3) tick();
    chk("err_pulses", 96'(err_cnt - e0), 96'(2));
    chk("err_no_writes", 96'(wr_cnt - w0), 96'(0));
    chk("err_no_start", 96'(start_cnt - s0), 96'(0));
    chk("err_busy_end", 96'(busy), 96'(0));

    // done already high on WAIT entry
    exp_len = 1; s0 = start_cnt;
    done = 1'b1;
    send_cmd(1);
    send_beats(16, 1'b0);
    for (int g = 0; g < 40 && start_cnt == s0; g++) tick();
    chk("dh_start", 96'(start_cnt), 96'(s0 + 1));
    repeat (5) tick();
    chk("dh_stays_wait", 96'(busy), 96'(1));
    done = 1'b0;
    repeat (2) tick();
    chk("dh_low_wait", 96'(busy), 96'(1));
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("dh_idle_busy", 96'(busy), 96'(0));
    chk("dh_idle_cmd_ready", 96'(cmd_ready), 96'(1));

    // reset after beat 100 of an n=10 burst
    exp_len = 10; s0 = start_cnt;
    send_cmd(10);
    send_beats(101, 1'b0);
    rst = 1'b1;
    tick();
    chk("mid_rst_outputs", {s_ready, load_features, start, busy, err_len, burst_len},
        96'(0));
    chk("mid_rst_addr_data", {feature_addr, features2}, 96'(0));
    chk("mid_rst_queue", 96'(exp_q.size()), 96'(0));
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", 96'(cmd_ready), 96'(1));
    repeat (5) tick();
    chk("mid_rst_no_start", 96'(start_cnt), 96'(s0));

    // fresh n=2 burst after reset
    exp_len = 2; s0 = start_cnt; w0 = wr_cnt;
    send_cmd(2);
    send_beats(32, 1'b0);
    finish_burst(s0);
    chk("n2_writes", 96'(wr_cnt - w0), 96'(32));
    chk("final_queue_empty", 96'(exp_q.size()), 96'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/feature_burst_loader.md
FEATURE_BURST_LOADER -- requirements
Module: feature_burst_loader

Interface
REQ-001 The block SHALL have parameter N_FEATURE, default 32, meaning 32-bit float features per sample; HALF_FEATURE = N_FEATURE/2 64-bit words per sample.
REQ-002 The block SHALL have parameter MAX_BURST, default 54, meaning max samples per accelerator run; MAX_BURST_BITS = $clog2(MAX_BURST).
REQ-003 The block SHALL have port clk  in  1  meaning the single clock, all logic on the rising edge.
REQ-004 The block SHALL have port rst  in  1  meaning reset, synchronous, active-high.
REQ-005 The block SHALL have ports cmd_valid in 1 / cmd_ready out 1 / cmd_n_samples in MAX_BURST_BITS, meaning the burst command handshake and its sample count.
REQ-006 The block SHALL have ports s_valid in 1 / s_ready out 1 / s_data in 64, meaning the feature stream: {feature[2k+1], feature[2k]} per beat, sample-major.
REQ-007 The block SHALL have ports load_features out 1 / feature_addr out 32 / features2 out 64, meaning the write port into the downstream tree accelerator feature buffer.
REQ-008 The block SHALL have ports start out 1 / burst_len out MAX_BURST_BITS / done in 1, meaning run control to and completion status from the accelerator.
REQ-009 The block SHALL have ports busy out 1 / err_len out 1, meaning busy when not IDLE and a one-cycle pulse on an illegal command.

Function
REQ-010 The FSM SHALL have states IDLE, LOAD, FLUSH, START, WAIT.
REQ-011 In IDLE, cmd_ready SHALL be 1 and all other handshakes 0; cmd_ready SHALL be 0 in every other state.
REQ-012 A command with cmd_n_samples == 0 or > MAX_BURST SHALL be consumed, pulse err_len for 1 cycle, and leave the FSM in IDLE.
REQ-013 A legal command SHALL latch n = cmd_n_samples into burst_len, clear the beat counter, and go to LOAD.
REQ-014 In LOAD, s_ready SHALL be 1; a beat SHALL be accepted when s_valid & s_ready.
REQ-015 An accepted beat SHALL appear one cycle later as load_features=1, features2=s_data, feature_addr=beat index (0-based, zero-extended to 32 bits).
REQ-016 A cycle with no accepted beat SHALL give load_features=0 next cycle, with feature_addr/features2 holding.
REQ-017 The beat counter SHALL be 10 bits (covers 54*16=864); acceptance of beat n*HALF_FEATURE-1 SHALL move LOAD->FLUSH and drop s_ready the next cycle.
REQ-018 FLUSH SHALL last exactly 1 cycle, during which the final write is presented, then go to START.
REQ-019 START SHALL assert start=1 for exactly 1 cycle with burst_len stable and load_features=0, then go to WAIT.
REQ-020 burst_len SHALL hold its value from command acceptance until return to IDLE.
REQ-021 WAIT SHALL return to IDLE on a rising edge of done (done=1 with a registered done_q=0); a done level already high on WAIT entry SHALL be ignored.
REQ-022 Beats presented outside LOAD SHALL NOT be accepted (s_ready=0); commands outside IDLE SHALL NOT be accepted.
REQ-023 Latency: the first write SHALL appear 2 cycles after the command handshake, given s_valid held high; start SHALL fire 2 cycles after the last beat acceptance.

Reset
REQ-024 While rst=1, the FSM SHALL go to IDLE, the counter to 0, and outputs to: cmd_ready=0 during reset, s_ready=0, load_features=0, feature_addr=0, features2=0, start=0, burst_len=0, busy=0, err_len=0, done_q=0.
REQ-025 Reset asserted mid-LOAD or mid-WAIT SHALL abort the burst with no further writes or start; the first cycle after rst=0 SHALL be IDLE with cmd_ready=1.

Structure
REQ-026 N_FEATURE, MAX_BURST, HALF_FEATURE, MAX_BURST_BITS and the FSM state enum SHALL live in a shared package trees_acc_pkg, also used by the accelerator and benches.
REQ-027 The block SHALL be a single module with no sub-module; the counter and FSM SHALL be inline.

Verification
REQ-028 Command n=1 with 16 back-to-back beats 0..15: the bench SHALL check writes addr 0..15 with matching data, start one cycle after FLUSH, and burst_len=1.
REQ-029 Command n=54 with random s_valid gaps: the bench SHALL check exactly 864 writes with addr 0..863 contiguous and no duplicates, and exactly one start pulse.
REQ-030 Command n=0, then n=60: the bench SHALL check err_len pulses twice, no writes, no start, and busy=0 throughout.
REQ-031 With done already high when WAIT is entered: the bench SHALL check that the FSM stays in WAIT until done falls then rises, then returns to IDLE with cmd_ready=1.
REQ-032 rst=1 after beat 100 of an n=10 burst: the bench SHALL check that all outputs are reset values next cycle, no start follows, and a fresh n=2 burst then completes with addr 0..31.
REQ-033 End-to-end with the tree accelerator and random n in 1..54 until 10000 samples are processed: the bench SHALL check that predictions match the software golden model.
